hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 4-stage execute path (ID -> EX -> MEM -> WB); 16-entry register file with 4-bit indices.
- Holds a registered scoreboard of in-flight destination registers.
- Produces the forwarding-mux selects for both register read ports, plus stall, bubble and flush controls:
  - load-use hazards;
  - taken branches resolved in EX;
  - memory wait states.
- Sits beside the register file and forwarding muxes in the decode stage; it drives the pipeline-register enables.

---
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destinations for EX/MEM/WB and
// derives forwarding selects plus stall, bubble, flush and freeze controls.
module hazard_ctrl #(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs0,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_use0,
  input  logic             id_use1,
  input  logic             id_wr,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_load,
  input  logic             ex_br_taken,
  input  logic             mem_ready,
  output logic [1:0]       fwd_sel0,
  output logic [1:0]       fwd_sel1,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] rd;
    logic             ld;
  } slot_t;

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, cnt_inc;
  logic m_ex0, m_ex1, m_mem0, m_mem1, m_wb0, m_wb1;
  logic lu;

  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] rs,
                                      input logic use_i);
    return s.v & s.wr & use_i & (s.rd == rs) & ~((ZERO_REG != 0) && (rs == '0));
  endfunction

  assign m_ex0  = slot_match(ex_q,  id_rs0, id_use0);
  assign m_ex1  = slot_match(ex_q,  id_rs1, id_use1);
  assign m_mem0 = slot_match(mem_q, id_rs0, id_use0);
  assign m_mem1 = slot_match(mem_q, id_rs1, id_use1);
  assign m_wb0  = slot_match(wb_q,  id_rs0, id_use0);
  assign m_wb1  = slot_match(wb_q,  id_rs1, id_use1);

  // A load in EX cannot forward yet, so a matching reader must wait one cycle.
  assign lu = id_valid & ex_q.ld & (m_ex0 | m_ex1);

  assign cnt_inc   = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
  assign stall_cnt = stall_cnt_q;

  // Forwarding selects: youngest producer wins.
  always_comb begin
    fwd_sel0 = 2'd0;
    fwd_sel1 = 2'd0;
    if (m_ex0 && !ex_q.ld) fwd_sel0 = 2'd1;
    else if (m_mem0)       fwd_sel0 = 2'd2;
    else if (m_wb0)        fwd_sel0 = 2'd3;
    if (m_ex1 && !ex_q.ld) fwd_sel1 = 2'd1;
    else if (m_mem1)       fwd_sel1 = 2'd2;
    else if (m_wb1)        fwd_sel1 = 2'd3;
  end

  // Event resolution in priority order: freeze, branch, load-use, normal advance.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    freeze      = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_ready) begin
      freeze      = 1'b1;
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      stall_cnt_d = cnt_inc;
    end else if (ex_br_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      ex_d      = '0;
      mem_d     = ex_q;
      wb_d      = mem_q;
    end else if (lu) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      bubble_ex   = 1'b1;
      ex_d        = '0;
      mem_d       = ex_q;
      wb_d        = mem_q;
      stall_cnt_d = cnt_inc;
    end else begin
      ex_d  = '{v: id_valid, wr: id_wr, rd: id_rd, ld: id_load};
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance (ZERO_REG=0, CNT_W=4)
// covers register-0 forwarding and counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_use0, id_use1, id_wr, id_load, ex_br_taken, mem_ready;
  logic [3:0] id_rs0, id_rs1, id_rd;

  logic [1:0]  fwd_sel0, fwd_sel1, s_fwd_sel0, s_fwd_sel1;
  logic        stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic        s_stall_if, s_stall_id, s_bubble_ex, s_flush_id, s_freeze;
  logic [15:0] stall_cnt;
  logic [3:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_use0(id_use0), .id_use1(id_use1), .id_wr(id_wr), .id_rd(id_rd), .id_load(id_load),
    .ex_br_taken(ex_br_taken), .mem_ready(mem_ready), .fwd_sel0(fwd_sel0),
    .fwd_sel1(fwd_sel1), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .freeze(freeze), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_W(4), .ZERO_REG(0), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_use0(id_use0), .id_use1(id_use1), .id_wr(id_wr), .id_rd(id_rd), .id_load(id_load),
    .ex_br_taken(ex_br_taken), .mem_ready(mem_ready), .fwd_sel0(s_fwd_sel0),
    .fwd_sel1(s_fwd_sel1), .stall_if(s_stall_if), .stall_id(s_stall_id),
    .bubble_ex(s_bubble_ex), .flush_id(s_flush_id), .freeze(s_freeze),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use0 = 0; id_use1 = 0; id_wr = 0; id_load = 0;
    id_rs0 = 0; id_rs1 = 0; id_rd = 0; ex_br_taken = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic instr(input logic wr, input logic [3:0] rd, input logic ld,
                       input logic u0, input logic [3:0] rs0,
                       input logic u1, input logic [3:0] rs1);
    id_valid = 1; id_wr = wr; id_rd = rd; id_load = ld;
    id_use0 = u0; id_rs0 = rs0; id_use1 = u1; id_rs1 = rs1;
  endtask

  initial begin
    reset_n = 0;
    idle();
    #1;
    // Reset and idle
    do_reset();
    #1;
    chk("rst_fwd0", 32'(fwd_sel0), 0);
    chk("rst_fwd1", 32'(fwd_sel1), 0);
    chk("rst_ctrl", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);

    // ALU r3 forwarding through EX, MEM, WB, then gone
    instr(1, 4'd3, 0, 0, 4'd0, 0, 4'd0);
    step();
    instr(0, 4'd0, 0, 1, 4'd3, 0, 4'd3);
    #1;
    chk("fwd_ex", 32'(fwd_sel0), 1);
    chk("fwd_unused_port", 32'(fwd_sel1), 0);
    step(); #1;
    chk("fwd_mem", 32'(fwd_sel0), 2);
    step(); #1;
    chk("fwd_wb", 32'(fwd_sel0), 3);
    step(); #1;
    chk("fwd_none", 32'(fwd_sel0), 0);

    // Load-use on rs1: one stall cycle, then forward from MEM
    do_reset();
    instr(1, 4'd5, 1, 0, 4'd0, 0, 4'd0);
    step();
    instr(0, 4'd0, 0, 0, 4'd0, 1, 4'd5);
    #1;
    chk("lu_ctrl", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 5'b11100);
    step(); #1;
    chk("lu_cnt", 32'(stall_cnt), 1);
    chk("lu_fwd1", 32'(fwd_sel1), 2);
    chk("lu_released", {29'd0, stall_if, stall_id, bubble_ex}, 0);

    // Taken branch coinciding with load-use: squash, no stall
    do_reset();
    instr(1, 4'd5, 1, 0, 4'd0, 0, 4'd0);
    step();
    instr(0, 4'd0, 0, 0, 4'd0, 1, 4'd5);
    ex_br_taken = 1;
    #1;
    chk("br_ctrl", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 5'b00110);
    step();
    ex_br_taken = 0;
    #1;
    chk("br_cnt", 32'(stall_cnt), 0);

    // Freeze for 3 cycles during a pending load-use, then the stall
    do_reset();
    instr(1, 4'd5, 1, 0, 4'd0, 0, 4'd0);
    step();
    instr(0, 4'd0, 0, 1, 4'd5, 0, 4'd0);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ctrl", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 5'b11001);
      chk("frz_fwd0", 32'(fwd_sel0), 0);
      step();
    end
    chk("frz_cnt3", 32'(stall_cnt), 3);
    mem_ready = 1;
    #1;
    chk("frz_then_lu", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 5'b11100);
    step(); #1;
    chk("frz_cnt4", 32'(stall_cnt), 4);
    chk("frz_fwd_mem", 32'(fwd_sel0), 2);

    // Register 0: hardwired zero vs. ordinary register
    do_reset();
    instr(1, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    step();
    instr(0, 4'd0, 0, 1, 4'd0, 0, 4'd0);
    #1;
    chk("r0_zero_reg", 32'(fwd_sel0), 0);
    chk("r0_plain_reg", 32'(s_fwd_sel0), 1);

    // Long freeze: 16-bit counter keeps counting, 4-bit counter saturates
    do_reset();
    mem_ready = 0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt16", 32'(stall_cnt), 20);
    chk("sat_cnt4", 32'(s_stall_cnt), 15);
    chk("sat_freeze", 32'(s_freeze), 1);

    // Reset mid-freeze clears the counter
    reset_n = 0;
    step();
    chk("rst_mid_freeze", 32'(stall_cnt), 0);
    reset_n = 1;
    idle();
    #1;
    chk("rst_idle_ctrl", {27'd0, stall_if, stall_id, bubble_ex, flush_id, freeze}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
